// File: rtl/vga_cam_pkg.sv
// Shared types and constants for the camera capture AHB master.
package vga_cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam int unsigned OVL_DIM   = 64;
  localparam int unsigned OVL_WORDS = 4096;

  typedef struct packed {
    logic [11:0] idx;
    logic        pix;
  } fifo_entry_t;

  // RGB565 -> 8-bit luma: (2R + 5G + B) / 8 with each channel widened to 8 bits.
  function automatic logic [7:0] luma(input logic [15:0] p);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [10:0] s;
    r8 = {p[15:11], p[15:13]};
    g8 = {p[10:5], p[10:9]};
    b8 = {p[4:0], p[4:2]};
    s  = {2'b00, r8, 1'b0} + {1'b0, g8, 2'b00} + {3'b000, g8} + {3'b000, b8};
    s  = s >> 3;
    return (s > 11'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/vga_cam_sync_fifo.sv
// Single-clock show-ahead FIFO; a pop frees a slot for a same-cycle push when full.
module vga_cam_sync_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_cam_capture_ahb.sv
// DVP RGB565 capture, 64x64 crop/decimate, threshold, AHB-Lite single writes.
module vga_cam_capture_ahb
  import vga_cam_pkg::*;
#(
  parameter logic [31:0] CAM_BASE   = 32'h4001_C000,
  parameter int unsigned X_OFF      = 192,
  parameter int unsigned Y_OFF      = 112,
  parameter int unsigned DEC        = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        enable,
  input  logic [7:0]  threshold,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_byte_en,
  input  logic [7:0]  cam_data,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned DEC_SH   = $clog2(DEC);
  localparam int unsigned OVL_SH   = $clog2(OVL_DIM);
  localparam logic [11:0] X_LO     = 12'(X_OFF);
  localparam logic [11:0] Y_LO     = 12'(Y_OFF);
  localparam logic [11:0] WIN      = 12'(OVL_DIM * DEC);
  localparam logic [11:0] DEC_MASK = 12'(DEC - 1);
  localparam logic [11:0] LAST_IDX = 12'(OVL_WORDS - 1);

  logic        vsync_q, href_q, run, phase;
  logic [7:0]  hi_byte;
  logic [11:0] x_cnt, y_cnt, rel_x, rel_y, idx_now;
  logic        frame_start, line_end, pix_stb, keep_now;
  logic        kept_valid;
  logic [15:0] kept_data;
  logic [11:0] kept_idx;
  logic        push_req;
  fifo_entry_t push_ent, fifo_dout, cur;
  logic        fifo_full, fifo_empty, pop;
  state_t      state, state_nxt;

  assign frame_start = vsync_q && !cam_vsync;
  assign line_end    = href_q && !cam_href;
  assign pix_stb     = cam_href && cam_byte_en && phase;
  assign rel_x       = x_cnt - X_LO;
  assign rel_y       = y_cnt - Y_LO;
  assign keep_now    = run
                    && (x_cnt >= X_LO) && (rel_x < WIN) && ((rel_x & DEC_MASK) == '0)
                    && (y_cnt >= Y_LO) && (rel_y < WIN) && ((rel_y & DEC_MASK) == '0);
  assign idx_now     = {rel_y[DEC_SH +: OVL_SH], rel_x[DEC_SH +: OVL_SH]};

  // Byte pairing, pixel/line counters and the kept-pixel stage.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      run        <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      kept_valid <= 1'b0;
      kept_data  <= '0;
      kept_idx   <= '0;
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      kept_valid <= pix_stb && keep_now && !frame_start;
      kept_data  <= {hi_byte, cam_data};
      kept_idx   <= idx_now;
      if (frame_start) begin
        x_cnt <= '0;
        y_cnt <= '0;
        phase <= 1'b0;
        run   <= enable;
      end else if (line_end) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 12'd1;
        phase <= 1'b0;
      end else if (cam_href && cam_byte_en) begin
        if (!phase) begin
          hi_byte <= cam_data;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          x_cnt <= x_cnt + 12'd1;
        end
      end
    end
  end

  // Luminance threshold stage feeding the FIFO; sticky drop flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      push_req <= 1'b0;
      push_ent <= '0;
      overflow <= 1'b0;
    end else begin
      push_req     <= kept_valid;
      push_ent.idx <= kept_idx;
      push_ent.pix <= (luma(kept_data) >= threshold);
      if (frame_start && enable)
        overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  vga_cam_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push_req),
    .din     (push_ent),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Master state register plus registered address/data/done outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      cur        <= '0;
      HADDR      <= '0;
      HWDATA     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == DATA) && HREADY && (cur.idx == LAST_IDX);
      if (pop) begin
        cur   <= fifo_dout;
        HADDR <= CAM_BASE + {18'b0, fifo_dout.idx, 2'b00};
      end
      if ((state == ADDR) && HREADY)
        HWDATA <= {31'b0, cur.pix};
    end
  end

  // Next-state and pop decode; DATA chains straight into ADDR when more is queued.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = ADDR;
      end
      ADDR: if (HREADY) state_nxt = DATA;
      DATA: if (HREADY) begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ADDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign HTRANS = (state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE = (state == ADDR);
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = '0;

endmodule

// File: tb/tb_vga_cam_capture_ahb.sv
// Scoreboard bench for vga_cam_capture_ahb: stimulus pushes expected writes, monitor pops.
module tb_vga_cam_capture_ahb;

  localparam logic [31:0] BASE = 32'h4001_C000;

  logic        HCLK = 1'b0;
  logic        HRESETn, enable, cam_vsync, cam_href, cam_byte_en, HREADY;
  logic [7:0]  threshold, cam_data;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, frame_done, overflow;
  logic [2:0]  HSIZE, HBURST;

  always #5 HCLK = ~HCLK;

  vga_cam_capture_ahb dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .enable      (enable),
    .threshold   (threshold),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_byte_en (cam_byte_en),
    .cam_data    (cam_data),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] last_addr = '0;
  int          pix_mode = 0;
  logic        stall_mon = 1'b0;
  logic        stall_have = 1'b0;
  logic [63:0] stall_ref = '0;
  int          stall_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: address phase captured on NONSEQ+HREADY, compared when the data phase completes.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        pending = 1'b0;
      end else begin
        if (pending && HREADY) begin
          pending = 1'b0;
          wr_cnt++;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %h data %h, expected no write", cap_addr, HWDATA);
          end else begin
            e = sb.pop_front();
            chk("write_addr", cap_addr, e.addr);
            chk("write_data", HWDATA, e.data);
          end
          last_addr = cap_addr;
        end else if (HTRANS == 2'b10 && HREADY) begin
          cap_addr = HADDR;
          pending  = 1'b1;
          chk("addr_ctrl", {25'b0, HWRITE, HSIZE, HBURST}, {25'b0, 1'b1, 3'b010, 3'b000});
        end
        if (frame_done) begin
          done_cnt++;
          chk("done_after_last", last_addr, 32'h4001_FFFC);
        end
      end
    end
  end

  // Stability watch for the stalled address phase.
  initial begin
    forever begin
      @(negedge HCLK);
      if (stall_mon && HTRANS == 2'b10) begin
        if (!stall_have) begin
          stall_ref  = {HADDR, HWDATA};
          stall_have = 1'b1;
        end else if ({HADDR, HWDATA} !== stall_ref || HWRITE !== 1'b1) begin
          stall_bad++;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  function automatic logic [15:0] pix_at(input int col);
    logic [15:0] p;
    case (pix_mode)
      1:       p = (col == 192) ? 16'h0000 : 16'hFFFF;
      2:       p = 16'h07E0;
      3:       p = ((col % 8) >= 4) ? 16'h0000 : 16'hFFFF;
      default: p = 16'hFFFF;
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic blank(input int n);
    repeat (n) begin
      cam_href = 1'b1;
      tick();
      cam_href = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic send_line(input int npix);
    logic [15:0] p;
    cam_href = 1'b1;
    tick();
    for (int c = 0; c < npix; c++) begin
      p = pix_at(c);
      cam_byte_en = 1'b1;
      cam_data    = p[15:8];
      tick();
      cam_data    = p[7:0];
      tick();
    end
    cam_byte_en = 1'b0;
    tick();
    cam_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic to_line112();
    frame_begin();
    blank(112);
  endtask

  task automatic push_exp(input int idx, input logic b);
    exp_t e;
    e.addr = BASE + 32'(idx) * 32'd4;
    e.data = {31'b0, b};
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((sb.size() != 0 || pending) && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    repeat (30) tick();
  endtask

  initial begin
    int w0;
    int d0;
    HRESETn = 1'b0; enable = 1'b1; threshold = 8'h80;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_byte_en = 1'b0; cam_data = '0;
    HREADY = 1'b1;
    repeat (3) tick();
    chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_flags", {29'b0, HWRITE, frame_done, overflow}, 32'd0);
    HRESETn = 1'b1;
    repeat (2) tick();

    // Dark pixel at the window origin, bright neighbours.
    pix_mode = 1; w0 = wr_cnt;
    push_exp(0, 1'b0); push_exp(1, 1'b1);
    to_line112(); send_line(197);
    drain("origin_drain", 500);
    chk("origin_count", 32'(wr_cnt - w0), 32'd2);

    // Threshold boundary on pure green (Y = 159).
    pix_mode = 2; threshold = 8'd159;
    push_exp(0, 1'b1);
    to_line112(); send_line(193);
    drain("thr159_drain", 500);
    threshold = 8'd160;
    push_exp(0, 1'b0);
    to_line112(); send_line(193);
    drain("thr160_drain", 500);

    // Bus stall: idx0 held in ADDR, idx1..8 fill the FIFO, idx9 is dropped.
    pix_mode = 3; threshold = 8'h80; w0 = wr_cnt;
    for (int k = 0; k < 9; k++) push_exp(k, (k % 2) == 0);
    to_line112();
    HREADY = 1'b0; stall_have = 1'b0; stall_bad = 0; stall_mon = 1'b1;
    send_line(229);
    repeat (10) tick();
    stall_mon = 1'b0;
    chk("stall_stable", 32'(stall_bad), 32'd0);
    chk("stall_haddr", HADDR, BASE);
    chk("stall_htrans", {30'b0, HTRANS}, 32'd2);
    chk("stall_overflow", {31'b0, overflow}, 32'd1);
    HREADY = 1'b1;
    drain("stall_drain", 200);
    chk("stall_count", 32'(wr_cnt - w0), 32'd9);
    chk("overflow_sticky", {31'b0, overflow}, 32'd1);

    // Reset asserted while a write is in its data phase.
    to_line112();
    HREADY = 1'b0;
    send_line(229);
    chk("pre_rst_overflow", {31'b0, overflow}, 32'd1);
    HREADY = 1'b1;
    tick();
    HREADY = 1'b0;
    chk("pre_rst_data_phase", {HWDATA[30:0], HTRANS == 2'b00}, {31'd1, 1'b1});
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    sb.delete();
    repeat (2) tick();
    HRESETn = 1'b1; HREADY = 1'b1; w0 = wr_cnt;
    repeat (20) tick();
    chk("post_rst_idle", {30'b0, HTRANS}, 32'd0);
    chk("post_rst_nowrites", 32'(wr_cnt - w0), 32'd0);
    pix_mode = 1; w0 = wr_cnt;
    push_exp(0, 1'b0); push_exp(1, 1'b1);
    to_line112(); send_line(197);
    drain("post_rst_drain", 500);
    chk("post_rst_count", 32'(wr_cnt - w0), 32'd2);

    // Enable sampled only at frame start.
    pix_mode = 0; w0 = wr_cnt;
    enable = 1'b0;
    frame_begin(); blank(50);
    enable = 1'b1;
    blank(62); send_line(197);
    repeat (100) tick();
    chk("disabled_nowrites", 32'(wr_cnt - w0), 32'd0);
    push_exp(0, 1'b1);
    to_line112(); send_line(193);
    drain("reenabled_drain", 500);
    chk("reenabled_count", 32'(wr_cnt - w0), 32'd1);

    // Full frame, all white: 4096 writes, then one frame_done.
    pix_mode = 0; w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 4096; i++) push_exp(i, 1'b1);
    frame_begin();
    blank(112);
    for (int r = 0; r < 256; r++) begin
      if ((r % 4) == 0) send_line(445);
      else blank(1);
    end
    blank(112);
    cam_vsync = 1'b1;
    drain("full_drain", 5000);
    chk("full_count", 32'(wr_cnt - w0), 32'd4096);
    chk("full_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("full_no_overflow", {31'b0, overflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_cam_capture_ahb.md
Name: vga_cam_capture_ahb

Overview:
- Upstream feeder for the VGA camera overlay memory.
- Captures an RGB565 DVP byte stream that is already synchronised to HCLK.
- Crops and decimates each frame to a 64x64 window and binarises every kept pixel against a programmable threshold.
- Writes each result bit, as an AHB-Lite master, into the VGA_CAM slave port: word index 0..4095, pixel in HWDATA[0]. A small FIFO decouples the pixel stream from bus stalls.

Parameters:
- CAM_BASE, 32'h4001_C000, byte address of overlay word 0; word n is at CAM_BASE + 4n.
- X_OFF, 192, first captured input column (pixels).
- Y_OFF, 112, first captured input line.
- DEC, 4, decimation factor in x and y, power of two; window is 64*DEC square.
- FIFO_DEPTH, 8, entries of {idx[11:0], bit}, power of two.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- enable  in  1  capture enable, sampled only at frame start.
- threshold  in  8  luminance threshold.
- cam_vsync  in  1  frame sync, high during vertical blank.
- cam_href  in  1  line valid.
- cam_byte_en  in  1  one-cycle strobe qualifying cam_data.
- cam_data  in  8  DVP byte, high byte of RGB565 first.
- HADDR  out  32  master address.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HWRITE  out  1  constant 1 during NONSEQ, 0 otherwise.
- HSIZE  out  3  constant 3'b010.
- HBURST  out  3  constant 3'b000.
- HWDATA  out  32  {31'b0, pixel bit}.
- HREADY  in  1  bus ready.
- frame_done  out  1  one-cycle pulse after the last bus write of a frame.
- overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full.

Behaviour:
- Reset values: HTRANS=0, HWRITE=0, HADDR=0, HWDATA=0, frame_done=0, overflow=0. FIFO empty, counters 0, FSM IDLE.
- Reset asserted mid-transfer aborts the transfer; no bus completion is owed.
- Frame start: falling edge of cam_vsync.
  - Clears x_cnt, y_cnt and the byte phase.
  - Latches enable into run; run stays frozen for the whole frame.
  - Clears overflow only when run=1.
- Byte pairing: while cam_href=1, a cam_byte_en with phase=0 stores the high byte; with phase=1 it forms pixel {hi,lo}, increments x_cnt and sets pix_valid for one cycle.
- Line end: falling edge of cam_href resets phase and x_cnt and increments y_cnt. An odd trailing byte is discarded.
- Keep rule: keep pixel when run=1, x_cnt in [X_OFF, X_OFF+64*DEC), y_cnt in the same range offset by Y_OFF, and (x_cnt-X_OFF)%DEC==0 and (y_cnt-Y_OFF)%DEC==0.
  - idx = ((y_cnt-Y_OFF)/DEC)*64 + (x_cnt-X_OFF)/DEC, 12 bits.
- Luminance: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y = (2*R8 + 5*G8 + B8) >> 3, computed in 11 bits and saturated to 8.
  - bit = (Y >= threshold).
  - One register stage; the FIFO push happens 1 cycle after pix_valid.
- FIFO: push when a pixel is kept and the FIFO is not full. Push while full drops the pixel and sets overflow. Pop is driven by the FSM. Simultaneous push and pop at full is allowed: the pop frees the slot and the push is accepted.
- Master FSM:
  - IDLE: if FIFO not empty, pop and go to ADDR. Drive HADDR=CAM_BASE+{idx,2'b00}, HTRANS=NONSEQ, HWRITE=1.
  - ADDR: hold the address-phase signals until HREADY=1, then go to DATA. Drive HTRANS=IDLE and HWDATA={31'b0,bit}.
  - DATA: hold HWDATA until HREADY=1.
    - If the FIFO is not empty, pop and go directly to ADDR with the next entry (back-to-back, 2 cycles per write at zero wait).
    - Otherwise go to IDLE.
  - Throughput at zero wait is 1 write per 2 HCLK; address and data phases are not overlapped.
- frame_done: pulse when DATA completes an entry with idx==4095.

Decomposition:
- Package vga_cam_pkg holds:
  - FSM enum {IDLE, ADDR, DATA}.
  - HTRANS_IDLE / HTRANS_NONSEQ and HSIZE_WORD constants.
  - Overlay geometry constants: 64, 4096.
  - fifo_entry_t struct {idx, bit}.
- One sub-module: vga_cam_sync_fifo, parameterised width/depth, with full/empty flags and same-cycle push/pop.

Test Plan:
- Full frame 640x480, every pixel 16'hFFFF, threshold 8'h80, HREADY=1 -> exactly 4096 writes. First HADDR 32'h4001_C000, last 32'h4001_FFFC, all HWDATA=1, then one frame_done pulse.
- Pixel 16'h0000 at column 192, line 112, rest 16'hFFFF -> idx 0 written with HWDATA=0. Column 193 is not written. Column 196 gives idx 1 with HWDATA=1.
- Threshold boundary -> pure green 16'h07E0 gives Y=159: threshold 159 writes 1, threshold 160 writes 0.
- HREADY held low 20 cycles during an ADDR phase while pixels stream -> address and data signals held stable; after 8 queued entries the next kept pixel sets overflow. Recovery resumes in FIFO order.
- enable=0 at vsync fall, then raised mid-frame -> no writes that frame; writes start the following frame.
- HRESETn pulsed low during DATA -> HTRANS=0 and overflow=0 immediately, FIFO empty; the next frame captures normally.
